// File: rtl/histogram_controller.sv
// histogram_controller: clears a bin RAM, accumulates pixel counts with
// read-modify-write forwarding and saturation, then serves bin readback.
module histogram_controller #(
    parameter int PIXEL_WIDTH = 8,
    parameter int HISTOGRAM_RAM_DATA_WIDTH = 17
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                frame_done,
    input  logic                                pixel_valid,
    input  logic [PIXEL_WIDTH-1:0]              pixel_value,
    output logic                                pixel_ready,
    output logic [PIXEL_WIDTH-1:0]              histogram_RAM_read_address,
    input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] histogram_RAM_read_data,
    output logic [PIXEL_WIDTH-1:0]              histogram_RAM_write_address,
    output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] histogram_RAM_write_data,
    output logic                                histogram_RAM_WE,
    input  logic                                read_request,
    input  logic [PIXEL_WIDTH-1:0]              read_bin,
    output logic                                read_valid,
    output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] read_data,
    output logic                                busy,
    output logic                                histogram_ready
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CLEAR      = 3'd1;
    localparam logic [2:0] ACCUMULATE = 3'd2;
    localparam logic [2:0] DRAIN      = 3'd3;
    localparam logic [2:0] READY      = 3'd4;
    localparam logic [PIXEL_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] MAX_COUNT = '1;

    logic [2:0]                          state;
    logic [PIXEL_WIDTH-1:0]              clr_addr;
    logic                                pend_valid;
    logic [PIXEL_WIDTH-1:0]              pend_addr;
    logic                                last_we;
    logic [PIXEL_WIDTH-1:0]              last_addr;
    logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] last_data;
    logic                                rd_valid_q;
    logic                                accept;
    logic                                pend_en;
    logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] count;
    logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] inc;

    always_comb begin
        accept = (state == ACCUMULATE) && pixel_valid;
        pend_en = pend_valid && (state == ACCUMULATE || state == DRAIN);
        // The RAM is read-first, so a write to the same bin last cycle is not yet visible
        count = (last_we && last_addr == pend_addr) ? last_data : histogram_RAM_read_data;
        inc = (count == MAX_COUNT) ? count : count + 1'b1;
        pixel_ready = state == ACCUMULATE;
        busy = state == CLEAR || state == ACCUMULATE || state == DRAIN;
        histogram_ready = state == READY;
        histogram_RAM_WE = state == CLEAR || pend_en;
        histogram_RAM_write_address = (state == CLEAR) ? clr_addr : (pend_en ? pend_addr : '0);
        histogram_RAM_write_data = pend_en ? inc : '0;
        histogram_RAM_read_address = (state == ACCUMULATE) ? pixel_value :
                                     (state == READY) ? read_bin : '0;
        read_valid = rd_valid_q;
        read_data = rd_valid_q ? histogram_RAM_read_data : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            clr_addr <= '0;
            pend_valid <= 1'b0;
            pend_addr <= '0;
            last_we <= 1'b0;
            last_addr <= '0;
            last_data <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            last_we <= histogram_RAM_WE;
            last_addr <= histogram_RAM_write_address;
            last_data <= histogram_RAM_write_data;
            pend_valid <= accept;
            pend_addr <= pixel_value;
            rd_valid_q <= (state == READY) && read_request && !start;
            case (state)
                IDLE, READY: begin
                    if (start) begin
                        state <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) state <= ACCUMULATE;
                end
                ACCUMULATE: if (frame_done) state <= DRAIN;
                DRAIN: state <= READY;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_histogram_controller.sv
// tb_histogram_controller: two controllers (17-bit and 2-bit bins) share
// stimulus; each is checked every cycle against an array-based histogram model.
module tb_histogram_controller;
    localparam longint MAX1 = (64'd1 << 17) - 1;
    localparam longint MAX2 = 3;

    logic clk = 0, rst = 1, start = 0, frame_done = 0, pixel_valid = 0, read_request = 0;
    logic [7:0] pixel_value = 0, read_bin = 0;

    logic pr1, we1, rv1, busy1, hr1, pr2, we2, rv2, busy2, hr2;
    logic [7:0] ra1, wa1, ra2, wa2;
    logic [16:0] wd1, rdat1, ram_rd1;
    logic [1:0] wd2, rdat2, ram_rd2;
    logic [16:0] ram1 [256];
    logic [1:0] ram2 [256];

    int errors = 0, checks = 0;

    histogram_controller #(.PIXEL_WIDTH(8), .HISTOGRAM_RAM_DATA_WIDTH(17)) dut1 (
        .clk(clk), .rst(rst), .start(start), .frame_done(frame_done),
        .pixel_valid(pixel_valid), .pixel_value(pixel_value), .pixel_ready(pr1),
        .histogram_RAM_read_address(ra1), .histogram_RAM_read_data(ram_rd1),
        .histogram_RAM_write_address(wa1), .histogram_RAM_write_data(wd1),
        .histogram_RAM_WE(we1), .read_request(read_request), .read_bin(read_bin),
        .read_valid(rv1), .read_data(rdat1), .busy(busy1), .histogram_ready(hr1));

    histogram_controller #(.PIXEL_WIDTH(8), .HISTOGRAM_RAM_DATA_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .frame_done(frame_done),
        .pixel_valid(pixel_valid), .pixel_value(pixel_value), .pixel_ready(pr2),
        .histogram_RAM_read_address(ra2), .histogram_RAM_read_data(ram_rd2),
        .histogram_RAM_write_address(wa2), .histogram_RAM_write_data(wd2),
        .histogram_RAM_WE(we2), .read_request(read_request), .read_bin(read_bin),
        .read_valid(rv2), .read_data(rdat2), .busy(busy2), .histogram_ready(hr2));

    always #5 clk = ~clk;

    // Read-first synchronous RAMs
    always @(posedge clk) begin
        ram_rd1 <= ram1[ra1];
        ram_rd2 <= ram2[ra2];
        if (we1) ram1[wa1] <= wd1;
        if (we2) ram2[wa2] <= wd2;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input int v, input longint m);
        return (v > m) ? m : v;
    endfunction

    // Behavioural model: phase 0 idle, 1 clearing, 2 counting, 3 draining, 4 ready
    int phase = 0, clr_i = 0, pend = 0, pend_p = 0, rv = 0, rv_bin = 0;
    int hist [256];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 0;
            pend <= 0;
            rv <= 0;
        end else begin
            rv <= (phase == 4 && read_request && !start) ? 1 : 0;
            rv_bin <= int'(read_bin);
            pend <= 0;
            if (phase == 0 || phase == 4) begin
                if (start) begin
                    phase <= 1;
                    clr_i <= 0;
                    foreach (hist[i]) hist[i] <= 0;
                end
            end else if (phase == 1) begin
                if (clr_i == 255) phase <= 2;
                else clr_i <= clr_i + 1;
            end else if (phase == 2) begin
                pend <= pixel_valid ? 1 : 0;
                pend_p <= int'(pixel_value);
                if (pixel_valid) hist[pixel_value] <= hist[pixel_value] + 1;
                if (frame_done) phase <= 3;
            end else begin
                phase <= 4;
            end
        end
    end

    logic e_busy, e_hr, e_pr, e_we, e_rv;
    always @(negedge clk) begin
        e_busy = !rst && phase >= 1 && phase <= 3;
        e_hr = !rst && phase == 4;
        e_pr = !rst && phase == 2;
        e_we = !rst && (phase == 1 || ((phase == 2 || phase == 3) && pend != 0));
        e_rv = !rst && rv != 0;
        chk("busy1", busy1, e_busy);
        chk("busy2", busy2, e_busy);
        chk("hist_ready1", hr1, e_hr);
        chk("hist_ready2", hr2, e_hr);
        chk("pixel_ready1", pr1, e_pr);
        chk("pixel_ready2", pr2, e_pr);
        chk("we1", we1, e_we);
        chk("we2", we2, e_we);
        if (e_we) begin
            chk("waddr1", wa1, phase == 1 ? clr_i : pend_p);
            chk("waddr2", wa2, phase == 1 ? clr_i : pend_p);
            chk("wdata1", wd1, phase == 1 ? 0 : sat(hist[pend_p], MAX1));
            chk("wdata2", wd2, phase == 1 ? 0 : sat(hist[pend_p], MAX2));
        end
        chk("read_valid1", rv1, e_rv);
        chk("read_valid2", rv2, e_rv);
        if (e_rv) begin
            chk("read_data1", rdat1, sat(hist[rv_bin], MAX1));
            chk("read_data2", rdat2, sat(hist[rv_bin], MAX2));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic with_req);
        start = 1;
        read_request = with_req;
        tick;
        start = 0;
        read_request = 0;
        if (with_req) chk("start_beats_read", rv1, 0);
        repeat (255) tick;
        chk("clear_last_pr", pr1, 0);
        tick;
        chk("clear_done_pr", pr1, 1);
    endtask

    task automatic pix(input int p);
        pixel_valid = 1;
        pixel_value = 8'(p);
        tick;
        pixel_valid = 0;
    endtask

    task automatic finish_frame;
        frame_done = 1;
        tick;
        frame_done = 0;
        tick;
    endtask

    task automatic rdq(input int b, input longint e1, input longint e2);
        read_request = 1;
        read_bin = 8'(b);
        tick;
        read_request = 0;
        chk("lit_rv", rv1, 1);
        chk($sformatf("lit_bin%0d_d1", b), rdat1, e1);
        chk($sformatf("lit_bin%0d_d2", b), rdat2, e2);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("reset_busy", busy1, 0);
        chk("reset_ready", hr1, 0);
        chk("reset_we", we1, 0);

        // 5,5,5 back to back: writes 1,2,3
        begin_frame(0);
        pixel_valid = 1;
        pixel_value = 5;
        tick;
        chk("w5_1", wd1, 1);
        tick;
        chk("w5_2", wd1, 2);
        tick;
        pixel_valid = 0;
        chk("w5_3", wd1, 3);
        chk("w5_addr", wa1, 5);
        finish_frame;
        chk("ready_after_drain", hr1, 1);
        rdq(5, 3, 3);

        // 7,9,7,7
        begin_frame(0);
        pixel_valid = 1;
        foreach (hist[i]) if (i < 4) begin
            pixel_value = (i == 1) ? 8'd9 : 8'd7;
            tick;
        end
        pixel_valid = 0;
        finish_frame;
        rdq(7, 3, 3);
        rdq(9, 1, 1);
        rdq(0, 0, 0);

        // five 3s: 2-bit counter saturates
        begin_frame(0);
        repeat (5) pix(3);
        finish_frame;
        rdq(3, 5, 3);

        // frame_done with last pixel in the same cycle
        begin_frame(0);
        pixel_valid = 1;
        pixel_value = 200;
        frame_done = 1;
        tick;
        pixel_valid = 0;
        frame_done = 0;
        chk("drain_not_ready", hr1, 0);
        tick;
        chk("ready_two_later", hr1, 1);
        rdq(200, 1, 1);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            begin_frame(f % 2 == 1);
            for (int n = $urandom_range(20, 200); n > 0; n--) begin
                pixel_valid = ($urandom % 4) != 0;
                pixel_value = ($urandom % 2 != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                frame_done = (n == 1);
                start = ($urandom % 16) == 0;
                tick;
            end
            pixel_valid = 0;
            frame_done = 0;
            start = 0;
            tick;
            for (int k = 0; k < 300; k++) begin
                read_request = ($urandom % 2) != 0;
                read_bin = ($urandom % 2 != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                pixel_valid = ($urandom % 2) != 0;
                pixel_value = 8'($urandom);
                frame_done = ($urandom % 8) == 0;
                tick;
            end
            read_request = 0;
            pixel_valid = 0;
            frame_done = 0;
        end

        // async reset mid-accumulate
        begin_frame(0);
        pixel_valid = 1;
        pixel_value = 42;
        tick;
        chk("pre_rst_we", we1, 1);
        #1 rst = 1;
        #1;
        chk("rst_busy", busy1, 0);
        chk("rst_pr", pr1, 0);
        chk("rst_we", we1, 0);
        chk("rst_hr", hr1, 0);
        pixel_valid = 0;
        tick;
        rst = 0;
        tick;
        chk("idle_after_rst", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
